// File: rtl/avr_irq_ctrl_pkg.sv
// Shared constants for the AVR interrupt controller: register offsets,
// FSM state encodings, ISTA layout and the priority encoder.
package avr_irq_ctrl_pkg;

   // I/O register offsets
   localparam logic [1:0] REG_IMSK = 2'd0;
   localparam logic [1:0] REG_IPND = 2'd1;
   localparam logic [1:0] REG_IEDG = 2'd2;
   localparam logic [1:0] REG_ISTA = 2'd3;

   // Request FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // ISTA layout: {active, 4'b0, in-service vector[2:0]}
   localparam int ISTA_ACT_BIT = 7;
   localparam int ISTA_VEC_W   = 3;

   // Index of the lowest set bit; 0 when nothing is set (caller checks |v)
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/avr_irq_ctrl_sync.sv
// W-wide 2-flop synchroniser for asynchronous IRQ lines, followed by a
// history flop so the top level sees both the level and a one-cycle rise.
module avr_irq_ctrl_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] lvl_o,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] s1_q, s2_q, prev_q;

   // Synchroniser chain plus previous-value flop; prev resets to 0 so a line
   // already high when reset is released is seen as a rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign lvl_o  = s2_q;
   assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/avr_irq_ctrl.sv
// Registered interrupt controller between peripheral IRQ sources and the
// AVR core: pending capture, mask, fixed lowest-index priority, and a
// request/acknowledge handshake with control registers on the I/O bus.
module avr_irq_ctrl
   import avr_irq_ctrl_pkg::*;
#(
   parameter int N_IRQ  = 4,
   parameter int VECT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_re,
   input  logic              io_we,
   input  logic [1:0]        io_a,
   input  logic [7:0]        io_do,
   output logic [7:0]        io_di,
   input  logic [N_IRQ-1:0]  irq_lines,
   output logic              iflag,
   output logic [VECT_W-1:0] ivect,
   input  logic              iack,
   input  logic [VECT_W-1:0] iack_vect
);

   logic [N_IRQ-1:0]      lvl, rise, eff;
   logic [N_IRQ-1:0]      imsk_q, iedg_q;
   logic [N_IRQ-1:0]      pend_q, pend_d;
   logic [N_IRQ-1:0]      ack_dec, sw_set, sw_clr;
   logic [1:0]            st_q, st_d;
   logic                  iflag_q, iflag_d;
   logic [VECT_W-1:0]     ivect_q, ivect_d, win;
   logic                  act_q, act_d;
   logic [ISTA_VEC_W-1:0] svec_q, svec_d;
   logic                  wr_imsk, wr_ipnd, wr_iedg, wr_ista;
   logic                  unused_io_do;

   avr_irq_ctrl_sync #(.W(N_IRQ)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (irq_lines),
      .lvl_o  (lvl),
      .rise_o (rise)
   );

   assign wr_imsk = io_we && (io_a == REG_IMSK);
   assign wr_ipnd = io_we && (io_a == REG_IPND);
   assign wr_iedg = io_we && (io_a == REG_IEDG);
   assign wr_ista = io_we && (io_a == REG_ISTA);

   // Only bits below N_IRQ and the ISTA active bit carry meaning
   assign unused_io_do = ^io_do;

   assign sw_set = wr_ista ? io_do[N_IRQ-1:0] : '0;
   assign sw_clr = wr_ipnd ? io_do[N_IRQ-1:0] : '0;

   // One-hot decode of the acknowledged vector
   always_comb begin
      ack_dec = '0;
      if (iack) begin
         for (int i = 0; i < N_IRQ; i++) begin
            if (iack_vect == VECT_W'(i)) ack_dec[i] = 1'b1;
         end
      end
   end

   // Edge bits: set beats clear; level bits simply follow the synced line
   assign pend_d = (iedg_q & (rise | sw_set | (pend_q & ~(sw_clr | ack_dec))))
                 | (~iedg_q & lvl);

   assign eff = pend_q & imsk_q;
   assign win = VECT_W'(lowest_set(8'(eff)));

   // Software-writable mask and edge-select registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imsk_q <= '0;
         iedg_q <= '0;
      end else begin
         if (wr_imsk) imsk_q <= io_do[N_IRQ-1:0];
         if (wr_iedg) iedg_q <= io_do[N_IRQ-1:0];
      end
   end

   // Pending register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend_q <= '0;
      else      pend_q <= pend_d;
   end

   // Request FSM next state: ivect is frozen while in REQ, iack beats withdraw
   always_comb begin
      st_d    = st_q;
      iflag_d = iflag_q;
      ivect_d = ivect_q;
      act_d   = act_q;
      svec_d  = svec_q;
      if (wr_ista && io_do[ISTA_ACT_BIT]) act_d = 1'b0;
      if (iack) act_d = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (|eff) begin
               ivect_d = win;
               iflag_d = 1'b1;
               st_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (iack) begin
               iflag_d = 1'b0;
               act_d   = 1'b1;
               svec_d  = ISTA_VEC_W'(iack_vect);
               st_d    = ST_HOLD;
            end else if (!eff[ivect_q]) begin
               iflag_d = 1'b0;
               st_d    = ST_IDLE;
            end
         end
         ST_HOLD: st_d = ST_IDLE;
         default: begin
            iflag_d = 1'b0;
            st_d    = ST_IDLE;
         end
      endcase
   end

   // FSM, request outputs and in-service status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= ST_IDLE;
         iflag_q <= 1'b0;
         ivect_q <= '0;
         act_q   <= 1'b0;
         svec_q  <= '0;
      end else begin
         st_q    <= st_d;
         iflag_q <= iflag_d;
         ivect_q <= ivect_d;
         act_q   <= act_d;
         svec_q  <= svec_d;
      end
   end

   assign iflag = iflag_q;
   assign ivect = ivect_q;

   // Read mux; drives zero when not selected so it can share a wor bus
   always_comb begin
      io_di = 8'h00;
      if (io_re) begin
         case (io_a)
            REG_IMSK: io_di = 8'(imsk_q);
            REG_IPND: io_di = 8'(pend_q);
            REG_IEDG: io_di = 8'(iedg_q);
            REG_ISTA: io_di = {act_q, 4'b0000, svec_q};
            default:  io_di = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Directed bench for avr_irq_ctrl: reset, edge/level capture, priority,
// withdraw, set-beats-clear and asynchronous reset during a request.
module tb_avr_irq_ctrl;

   localparam logic [1:0] A_IMSK = 2'd0;
   localparam logic [1:0] A_IPND = 2'd1;
   localparam logic [1:0] A_IEDG = 2'd2;
   localparam logic [1:0] A_ISTA = 2'd3;

   logic       clk, rst, io_re, io_we, iflag, iack;
   logic [1:0] io_a, ivect, iack_vect;
   logic [7:0] io_do, io_di, rd_v;
   logic [3:0] irq_lines;
   int         n_cmp = 0;
   int         n_err = 0;

   avr_irq_ctrl #(.N_IRQ(4), .VECT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .io_re     (io_re),
      .io_we     (io_we),
      .io_a      (io_a),
      .io_do     (io_do),
      .io_di     (io_di),
      .irq_lines (irq_lines),
      .iflag     (iflag),
      .ivect     (ivect),
      .iack      (iack),
      .iack_vect (iack_vect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      io_a = a; io_do = d; io_we = 1'b1;
      @(negedge clk);
      io_we = 1'b0; io_do = 8'h00;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      io_a = a; io_re = 1'b1;
      #1 d = io_di;
      io_re = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; irq_lines = 4'hF; io_re = 1'b0; io_we = 1'b0;
      io_a = 2'd0; io_do = 8'h00; iack = 1'b0; iack_vect = 2'd0;
      cyc(3);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL reset_iflag: got %b want 0", iflag); end
      n_cmp++; if (ivect !== 2'd0) begin n_err++; $display("FAIL reset_ivect: got %0d want 0", ivect); end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), rd_v);
         n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", a, rd_v); end
      end
      rst = 1'b1;
      cyc(2);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL post_reset_early: got %h want 00", rd_v); end
      cyc(1);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h0F) begin n_err++; $display("FAIL post_reset_level: got %h want 0f", rd_v); end
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL post_reset_masked: got %b want 0", iflag); end
      irq_lines = 4'h0;
      cyc(4);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL post_reset_drop: got %h want 00", rd_v); end
   endtask

   task automatic test_edge_single;
      wr(A_IMSK, 8'hFF);
      rd(A_IMSK, rd_v);
      n_cmp++; if (rd_v !== 8'h0F) begin n_err++; $display("FAIL imsk_width: got %h want 0f", rd_v); end
      io_a = A_IMSK;
      #1;
      n_cmp++; if (io_di !== 8'h00) begin n_err++; $display("FAIL io_di_idle: got %h want 00", io_di); end
      wr(A_IEDG, 8'h0F);
      irq_lines = 4'b0100;
      cyc(1);
      irq_lines = 4'b0000;
      cyc(2);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h04) begin n_err++; $display("FAIL edge_pend: got %h want 04", rd_v); end
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL edge_flag_early: got %b want 0", iflag); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b1) begin n_err++; $display("FAIL edge_flag: got %b want 1", iflag); end
      n_cmp++; if (ivect !== 2'd2) begin n_err++; $display("FAIL edge_vect: got %0d want 2", ivect); end
      iack = 1'b1; iack_vect = 2'd2;
      cyc(1);
      iack = 1'b0;
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL edge_ack_flag: got %b want 0", iflag); end
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL edge_ack_pend: got %h want 00", rd_v); end
      rd(A_ISTA, rd_v);
      n_cmp++; if (rd_v !== 8'h82) begin n_err++; $display("FAIL edge_ista: got %h want 82", rd_v); end
      cyc(2);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL edge_flag_stays: got %b want 0", iflag); end
      wr(A_ISTA, 8'h80);
      rd(A_ISTA, rd_v);
      n_cmp++; if (rd_v !== 8'h02) begin n_err++; $display("FAIL ista_clear: got %h want 02", rd_v); end
   endtask

   task automatic test_priority;
      irq_lines = 4'b1010;
      cyc(4);
      n_cmp++; if (iflag !== 1'b1) begin n_err++; $display("FAIL prio_flag: got %b want 1", iflag); end
      n_cmp++; if (ivect !== 2'd1) begin n_err++; $display("FAIL prio_vect: got %0d want 1", ivect); end
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h0A) begin n_err++; $display("FAIL prio_pend: got %h want 0a", rd_v); end
      iack = 1'b1; iack_vect = 2'd1;
      cyc(1);
      iack = 1'b0;
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL prio_hold_flag: got %b want 0", iflag); end
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h08) begin n_err++; $display("FAIL prio_ack_pend: got %h want 08", rd_v); end
      rd(A_ISTA, rd_v);
      n_cmp++; if (rd_v !== 8'h81) begin n_err++; $display("FAIL prio_ista1: got %h want 81", rd_v); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL prio_idle_flag: got %b want 0", iflag); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b1) begin n_err++; $display("FAIL prio_second_flag: got %b want 1", iflag); end
      n_cmp++; if (ivect !== 2'd3) begin n_err++; $display("FAIL prio_second_vect: got %0d want 3", ivect); end
      iack = 1'b1; iack_vect = 2'd3;
      cyc(1);
      iack = 1'b0;
      rd(A_ISTA, rd_v);
      n_cmp++; if (rd_v !== 8'h83) begin n_err++; $display("FAIL prio_ista2: got %h want 83", rd_v); end
      irq_lines = 4'b0000;
      cyc(3);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL prio_quiet: got %b want 0", iflag); end
      wr(A_ISTA, 8'h80);
   endtask

   task automatic test_withdraw;
      wr(A_IMSK, 8'h02);
      irq_lines = 4'b0010;
      cyc(1);
      irq_lines = 4'b0000;
      cyc(3);
      n_cmp++; if (iflag !== 1'b1 || ivect !== 2'd1) begin n_err++; $display("FAIL wd_req: got %b/%0d want 1/1", iflag, ivect); end
      wr(A_IMSK, 8'h00);
      cyc(1);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL wd_flag: got %b want 0", iflag); end
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h02) begin n_err++; $display("FAIL wd_pend: got %h want 02", rd_v); end
      wr(A_IPND, 8'h02);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL wd_sw_clear: got %h want 00", rd_v); end
   endtask

   task automatic test_level;
      wr(A_IEDG, 8'h00);
      wr(A_IMSK, 8'h01);
      irq_lines = 4'b0001;
      cyc(4);
      n_cmp++; if (iflag !== 1'b1 || ivect !== 2'd0) begin n_err++; $display("FAIL lvl_req: got %b/%0d want 1/0", iflag, ivect); end
      iack = 1'b1; iack_vect = 2'd0;
      cyc(1);
      iack = 1'b0;
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL lvl_hold: got %b want 0", iflag); end
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h01) begin n_err++; $display("FAIL lvl_ack_keeps: got %h want 01", rd_v); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL lvl_idle: got %b want 0", iflag); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b1) begin n_err++; $display("FAIL lvl_reassert: got %b want 1", iflag); end
      irq_lines = 4'b0000;
      cyc(2);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h01) begin n_err++; $display("FAIL lvl_drop_early: got %h want 01", rd_v); end
      cyc(1);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL lvl_drop: got %h want 00", rd_v); end
      cyc(1);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL lvl_withdraw: got %b want 0", iflag); end
      wr(A_ISTA, 8'h01);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL lvl_sw_set: got %h want 00", rd_v); end
      wr(A_ISTA, 8'h80);
   endtask

   task automatic test_set_wins;
      wr(A_IMSK, 8'h00);
      wr(A_IEDG, 8'h01);
      irq_lines = 4'b0001;
      cyc(1);
      irq_lines = 4'b0000;
      cyc(2);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h01) begin n_err++; $display("FAIL sw_first_edge: got %h want 01", rd_v); end
      cyc(3);
      irq_lines = 4'b0001;
      cyc(1);
      irq_lines = 4'b0000;
      cyc(1);
      io_a = A_IPND; io_do = 8'h01; io_we = 1'b1;
      cyc(1);
      io_we = 1'b0; io_do = 8'h00;
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h01) begin n_err++; $display("FAIL set_wins: got %h want 01", rd_v); end
      wr(A_IPND, 8'h01);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL clear_alone: got %h want 00", rd_v); end
      wr(A_ISTA, 8'h01);
      rd(A_IPND, rd_v);
      n_cmp++; if (rd_v !== 8'h01) begin n_err++; $display("FAIL edge_sw_set: got %h want 01", rd_v); end
      wr(A_IPND, 8'h01);
   endtask

   task automatic test_reset_in_req;
      wr(A_IMSK, 8'h01);
      irq_lines = 4'b0001;
      cyc(1);
      irq_lines = 4'b0000;
      cyc(3);
      n_cmp++; if (iflag !== 1'b1) begin n_err++; $display("FAIL rreq_flag: got %b want 1", iflag); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL rreq_async: got %b want 0", iflag); end
      rd(A_IMSK, rd_v);
      n_cmp++; if (rd_v !== 8'h00) begin n_err++; $display("FAIL rreq_imsk: got %h want 00", rd_v); end
      cyc(2);
      rst = 1'b1;
      cyc(4);
      n_cmp++; if (iflag !== 1'b0) begin n_err++; $display("FAIL rreq_dropped: got %b want 0", iflag); end
   endtask

   initial begin
      test_reset;
      test_edge_single;
      test_priority;
      test_withdraw;
      test_level;
      test_set_wins;
      test_reset_in_req;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
